// File: rtl/fifo_drain_ctrl.sv
// Read side of a packet FIFO: tracks stored entries and streams each entry
// out byte by byte (head, length, payload) over a valid/ready interface.
module fifo_drain_ctrl #(
    parameter int DEPTH     = 3,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_push,
    output logic                 read_en,
    output logic [PTR_SZ-1:0]    raddr,
    output logic [PTR_IN_SZ-1:0] raddr_in,
    input  logic [UWIDTH-1:0]    rdata,
    output logic [UWIDTH-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 entry_pop,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf,
    output logic                 len_err
);

    localparam int CNT_SZ = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HEAD, LENGTH, PAYLOAD} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_SZ-1:0]      count_reg;
    logic [PTR_SZ-1:0]      rd_ptr_reg;
    logic [PTR_IN_SZ-1:0]   idx_reg;
    logic [PTR_IN_SZ-1:0]   last_idx_reg;
    logic                   load;
    logic                   is_last;
    logic                   pop;
    logic                   push_ok;
    logic                   more;
    logic                   len_over;
    logic [PTR_IN_SZ-1:0]   len_last_idx;

    assign full     = (count_reg == CNT_SZ'(DEPTH));
    assign empty    = (count_reg == '0);
    assign raddr    = rd_ptr_reg;
    assign raddr_in = idx_reg;

    // A full FIFO still takes a push when an entry is freed in the same cycle.
    assign push_ok = entry_push && (!full || pop);
    assign more    = (count_reg > CNT_SZ'(1)) || entry_push;

    // Length field bounds: anything past WIDTH-2 payload bytes is clamped.
    assign len_over     = 32'(rdata) > 32'(WIDTH - 2);
    assign len_last_idx = len_over ? PTR_IN_SZ'(WIDTH - 1) : PTR_IN_SZ'(32'(rdata) + 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0) state_next = HEAD;
            HEAD:    if (load) state_next = LENGTH;
            LENGTH:  if (load) state_next = is_last ? (more ? HEAD : IDLE) : PAYLOAD;
            PAYLOAD: if (pop) state_next = more ? HEAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load    = (state_reg != IDLE) && (!out_valid || out_ready);
        is_last = 1'b0;
        case (state_reg)
            LENGTH:  is_last = (rdata == '0);
            PAYLOAD: is_last = (idx_reg == last_idx_reg);
            default: is_last = 1'b0;
        endcase
        pop     = load && is_last;
        read_en = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            idx_reg      <= '0;
            last_idx_reg <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            entry_pop    <= 1'b0;
            ovf          <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            entry_pop <= pop;
            ovf       <= entry_push && full && !pop;
            len_err   <= load && (state_reg == LENGTH) && len_over;

            if (push_ok && !pop) begin
                count_reg <= count_reg + CNT_SZ'(1);
            end else if (pop && !push_ok) begin
                count_reg <= count_reg - CNT_SZ'(1);
            end

            if (load) begin
                out_data  <= rdata;
                out_valid <= 1'b1;
                out_last  <= is_last;
                idx_reg   <= is_last ? '0 : idx_reg + PTR_IN_SZ'(1);
                if (state_reg == LENGTH) begin
                    last_idx_reg <= len_last_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_SZ'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_SZ'(1);
            end
        end
    end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of packet entries in the FIFO memory.
REQ-002 SHALL have parameter WIDTH, default 11: bytes per entry.
REQ-003 SHALL have parameter UWIDTH, default 8: bits per byte.
REQ-004 SHALL have parameter PTR_SZ, default 2: entry index width.
REQ-005 SHALL have parameter PTR_IN_SZ, default 4: byte-within-entry index width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port entry_push, input, 1 bit: writer has completed one entry.
REQ-010 SHALL have port read_en, output, 1 bit: memory read strobe.
REQ-011 SHALL have port raddr, output, PTR_SZ bits: entry being read.
REQ-012 SHALL have port raddr_in, output, PTR_IN_SZ bits: byte index within that entry.
REQ-013 SHALL have port rdata, input, UWIDTH bits: memory read data, combinational from raddr/raddr_in.
REQ-014 SHALL have port out_data, output, UWIDTH bits: registered output byte.
REQ-015 SHALL have port out_valid, output, 1 bit: out_data holds a byte.
REQ-016 SHALL have port out_ready, input, 1 bit: sink accepts the byte.
REQ-017 SHALL have port out_last, output, 1 bit: out_data is the final byte of the packet.
REQ-018 SHALL have port entry_pop, output, 1 bit: one-cycle pulse, entry freed.
REQ-019 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-020 SHALL have port empty, output, 1 bit: count == 0.
REQ-021 SHALL have port ovf, output, 1 bit: one-cycle pulse, push dropped.
REQ-022 SHALL have port len_err, output, 1 bit: one-cycle pulse, length field out of range.

Function
REQ-023 SHALL keep count (0..DEPTH): +1 on entry_push when not full; -1 on entry_pop; unchanged when both occur in the same cycle.
REQ-024 SHALL drop entry_push when full and no pop in the same cycle, pulse ovf the next cycle, and leave count unchanged.
REQ-025 SHALL have FSM states IDLE, HEAD, LENGTH, PAYLOAD; IDLE->HEAD when count>0.
REQ-026 SHALL define load = (state != IDLE) && (!out_valid || out_ready); read_en = load.
REQ-027 On load, SHALL register rdata into out_data, set out_valid, and increment raddr_in; raddr = rd_ptr.
REQ-028 HEAD: load byte 0, then go to LENGTH; LENGTH: load byte 1, capture L = rdata, set total = L+2, then go to PAYLOAD, or finish if L==0.
REQ-029 If L > WIDTH-2, SHALL clamp total to WIDTH and pulse len_err for one cycle following the byte-1 load.
REQ-030 SHALL set out_last together with the byte at index total-1 and clear it on that byte's handshake.
REQ-031 On the last-byte load, SHALL pulse entry_pop, advance rd_ptr (DEPTH-1 wraps to 0), reset raddr_in to 0, and go to HEAD if (count-1)>0 or a push arrives in the same cycle, else IDLE.
REQ-032 Throughput SHALL be one byte/cycle with out_ready high; back-to-back packets SHALL have no bubble.
REQ-033 out_valid SHALL drop only after a handshake with no new load; out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-034 Latency: with IDLE and empty, a push sampled at edge N SHALL give out_valid high after edge N+2.

Reset
REQ-035 rst_n low SHALL asynchronously clear state to IDLE, count, rd_ptr and raddr_in to 0, and out_data, out_valid, out_last, entry_pop, ovf and len_err to 0; empty=1, full=0.
REQ-036 Reset mid-packet SHALL discard the partial packet with no entry_pop pulse; operation SHALL resume from the first rising edge after deassertion.

Verification
REQ-037 Single push, entry {0xA5,0x03,0x11,0x22,0x33}, out_ready=1 -> bytes A5,03,11,22,33 on consecutive cycles, out_last on 0x33, one entry_pop, empty=1.
REQ-038 Three pushes, then one more push -> full=1, ovf pulse, count stays 3; all three entries drain in order at raddr 0,1,2 and rd_ptr wraps to 0.
REQ-039 Length byte 0x00 -> 2-byte packet with out_last on byte 1; length byte 0x0F -> 11 bytes out, len_err pulse.
REQ-040 out_ready toggled 1,0,0,1 mid-payload -> out_data/out_last held during stall, no byte lost or duplicated.
REQ-041 rst_n low during PAYLOAD byte 4 -> all outputs 0 immediately, no entry_pop; next push reads entry 0 from byte 0.
REQ-042 Push coincident with last-byte pop at count=1 -> count stays 1, next HEAD follows with no bubble.
